// File: rtl/riscv_definitions.sv
// rtl/riscv_definitions.sv - shared RISC-V encodings and memory-controller types
// Purpose: funct3 encodings for LOAD/STORE, memory access size, data memory FSM states.
// Ports: none (package).
package riscv_definitions;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3ITypeLOAD_e;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } funct3STypeSTORE_e;

  // Access size, taken straight from funct3[1:0].
  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } memSize_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10
  } dmemState_e;

endpackage

// File: rtl/dmem_store_align.sv
// rtl/dmem_store_align.sv - byte-enable, store-data replication and misalignment detection
// Purpose: combinational lane steering for one data memory access.
// Ports:
//   addr_lo    in  2   byte offset within the word
//   size       in  2   access size (memSize_e)
//   rs2_data   in  32  raw store data from ex
//   be         out 4   byte enables
//   wdata      out 32  lane-replicated store data
//   misaligned out 1   half on odd address, or word not on a word boundary
module dmem_store_align
  import riscv_definitions::*;
(
  input  logic [1:0]  addr_lo,
  input  memSize_e    size,
  input  logic [31:0] rs2_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b1111;
    wdata      = rs2_data;
    misaligned = 1'b0;
    case (size)
      MEM_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{rs2_data[7:0]}};
      end
      MEM_H: begin
        // addr_lo[0] is dropped, so a misaligned half lands on the aligned pair.
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata      = {2{rs2_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        // Word, and the unused size encoding 2'b11, behave as a full word.
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-outstanding data memory controller between ex and ma
// Purpose: turns ex load/store requests into one req/ack bus transaction, right-aligns
//   load data for ma and stalls the pipeline while the transaction is in flight.
// Config macro: MISALIGN_TRAP_EN - when defined, misaligned accesses skip the bus and
//   pulse misalign_exc; when undefined, offending low address bits are forced to 0.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   alu_result, rs2_data             effective address and store data from ex
//   mem_rd_en, mem_wr_en, mem_funct3 load/store request and size/sign
//   dmem_req, dmem_we, dmem_addr,
//   dmem_be, dmem_wdata              bus request side
//   dmem_ack, dmem_rdata             bus completion and read data
//   data                             right-aligned load data to ma
//   stall                            combinational pipeline freeze
//   misalign_exc                     one-cycle misaligned-access pulse
module data_mem_ctrl
  import riscv_definitions::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [2:0]        mem_funct3,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] data,
  output logic              stall,
  output logic              misalign_exc
);

  dmemState_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [1:0]        off_q, off_d;
  memSize_e          size_q, size_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              misalign_q, misalign_d;

  memSize_e          size;
  logic [3:0]        be_calc;
  logic [DATA_W-1:0] wdata_calc;
  logic              misaligned;
  logic [1:0]        off_eff;
  logic              trap;
  logic [DATA_W-1:0] rdata_shift;
  logic [DATA_W-1:0] rdata_aligned;
  logic              unused_sign;

  // Sign/unsigned selection is ma's job; only the size bits matter here.
  assign unused_sign = mem_funct3[2];
  assign size        = memSize_e'(mem_funct3[1:0]);

  dmem_store_align u_store_align (
    .addr_lo    (alu_result[1:0]),
    .size       (size),
    .rs2_data   (rs2_data),
    .be         (be_calc),
    .wdata      (wdata_calc),
    .misaligned (misaligned)
  );

  // Lane offset used to right-align load data; misaligned low bits are dropped,
  // matching the byte enables the aligner produces.
  always_comb begin
    case (size)
      MEM_B:   off_eff = alu_result[1:0];
      MEM_H:   off_eff = {alu_result[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = misaligned;
  assign trap              = 1'b0;
`endif

  // Right-align and zero the lanes above the access size so ma sees only the loaded bytes.
  assign rdata_shift = dmem_rdata >> {off_q, 3'b000};
  always_comb begin
    case (size_q)
      MEM_B:   rdata_aligned = {{(DATA_W-8){1'b0}}, rdata_shift[7:0]};
      MEM_H:   rdata_aligned = {{(DATA_W-16){1'b0}}, rdata_shift[15:0]};
      default: rdata_aligned = rdata_shift;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    off_d      = off_q;
    size_d     = size_q;
    data_d     = data_q;
    misalign_d = 1'b0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_rd_en || mem_wr_en) begin
          stall = 1'b1;
          if (trap) begin
            state_d    = DONE;
            misalign_d = 1'b1;
          end else begin
            state_d = BUS;
            addr_d  = {alu_result[ADDR_W-1:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            we_d    = mem_wr_en;
            off_d   = off_eff;
            size_d  = size;
          end
        end
      end
      BUS: begin
        stall = 1'b1;
        if (dmem_ack) begin
          state_d = DONE;
          if (!we_q) data_d = rdata_aligned;
        end
      end
      // The ex request is still present here; it is the one just completed.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      off_q      <= 2'b00;
      size_q     <= MEM_B;
      data_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      off_q      <= off_d;
      size_q     <= size_d;
      data_q     <= data_d;
      misalign_q <= misalign_d;
    end
  end

  assign dmem_req     = (state_q == BUS);
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign data         = data_q;
  assign misalign_exc = misalign_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_result = '0;
  logic [31:0] rs2_data = '0;
  logic        mem_rd_en = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic [2:0]  mem_funct3 = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] data;
  logic        stall;
  logic        misalign_exc;

  int total = 0;
  int bad = 0;

  int          stall_cnt, req_cnt, exc_cnt;
  logic [31:0] cap_addr, cap_wdata, done_data;
  logic [3:0]  cap_be;
  logic        cap_we, stable, done_exc, timed_out, post_stall, post_exc, post_req;

  data_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result   (alu_result),
    .rs2_data     (rs2_data),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_funct3   (mem_funct3),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .data         (data),
    .stall        (stall),
    .misalign_exc (misalign_exc)
  );

  always #5 clk = ~clk;

  // Holds one ex request until stall drops, acking on the k-th bus cycle, and records
  // what the bus and pipeline-side outputs did along the way.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [2:0] f3, input int k,
                            input logic [31:0] rdata);
    logic got;
    stall_cnt = 0; req_cnt = 0; exc_cnt = 0; stable = 1'b1; got = 1'b0;
    timed_out = 1'b1; done_data = '0; done_exc = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    @(posedge clk); #1;
    mem_rd_en = rd; mem_wr_en = wr; alu_result = a; rs2_data = wd; mem_funct3 = f3;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (dmem_req) req_cnt++;
      dmem_ack   = dmem_req && (req_cnt == k);
      dmem_rdata = dmem_ack ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      if (misalign_exc) exc_cnt++;
      if (dmem_req) begin
        if (!got) begin
          cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata; cap_we = dmem_we;
          got = 1'b1;
        end else if (cap_addr !== dmem_addr || cap_be !== dmem_be ||
                     cap_wdata !== dmem_wdata || cap_we !== dmem_we) begin
          stable = 1'b0;
        end
      end
      if (stall) begin
        stall_cnt++;
      end else begin
        done_data = data; done_exc = misalign_exc; timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    post_stall = stall; post_exc = misalign_exc; post_req = dmem_req;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
    total++; if (dmem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", dmem_we); end
    total++; if (dmem_be !== 4'h0) begin bad++; $display("FAIL rst_be got=%h exp=0", dmem_be); end
    total++; if (dmem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", dmem_addr); end
    total++; if (dmem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", dmem_wdata); end
    total++; if (data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", data); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    total++; if (misalign_exc !== 1'b0) begin bad++; $display("FAIL rst_exc got=%b exp=0", misalign_exc); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sw_fast;
    run_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1, 32'h0);
    total++; if (timed_out) begin bad++; $display("FAIL sw_timeout got=1 exp=0"); end
    total++; if (cap_addr !== 32'h100) begin bad++; $display("FAIL sw_addr got=%h exp=00000100", cap_addr); end
    total++; if (cap_be !== 4'b1111) begin bad++; $display("FAIL sw_be got=%b exp=1111", cap_be); end
    total++; if (cap_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_wdata got=%h exp=deadbeef", cap_wdata); end
    total++; if (cap_we !== 1'b1) begin bad++; $display("FAIL sw_we got=%b exp=1", cap_we); end
    total++; if (stall_cnt != 2) begin bad++; $display("FAIL sw_stall got=%0d exp=2", stall_cnt); end
    total++; if (req_cnt != 1) begin bad++; $display("FAIL sw_req_cycles got=%0d exp=1", req_cnt); end
    total++; if (done_data !== 32'h0) begin bad++; $display("FAIL sw_data_kept got=%h exp=0", done_data); end
    total++; if (post_stall !== 1'b0 || post_req !== 1'b0) begin bad++; $display("FAIL sw_idle_after got=%b%b exp=00", post_stall, post_req); end
  endtask

  task automatic test_sb_slow;
    run_access(1'b0, 1'b1, 32'h203, 32'h123456A5, 3'b000, 3, 32'h0);
    total++; if (timed_out) begin bad++; $display("FAIL sb_timeout got=1 exp=0"); end
    total++; if (cap_addr !== 32'h200) begin bad++; $display("FAIL sb_addr got=%h exp=00000200", cap_addr); end
    total++; if (cap_be !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", cap_be); end
    total++; if (cap_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", cap_wdata); end
    total++; if (!stable) begin bad++; $display("FAIL sb_stable got=0 exp=1"); end
    total++; if (req_cnt != 3) begin bad++; $display("FAIL sb_req_cycles got=%0d exp=3", req_cnt); end
    total++; if (stall_cnt != 4) begin bad++; $display("FAIL sb_stall got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_loads;
    run_access(1'b1, 1'b0, 32'h302, 32'h0, 3'b001, 1, 32'h80011234);
    total++; if (timed_out) begin bad++; $display("FAIL lh_timeout got=1 exp=0"); end
    total++; if (cap_be !== 4'b1100) begin bad++; $display("FAIL lh_be got=%b exp=1100", cap_be); end
    total++; if (cap_addr !== 32'h300) begin bad++; $display("FAIL lh_addr got=%h exp=00000300", cap_addr); end
    total++; if (cap_we !== 1'b0) begin bad++; $display("FAIL lh_we got=%b exp=0", cap_we); end
    total++; if (done_data !== 32'h00008001) begin bad++; $display("FAIL lh_data got=%h exp=00008001", done_data); end
    run_access(1'b1, 1'b0, 32'h301, 32'h0, 3'b100, 2, 32'h80011234);
    total++; if (cap_be !== 4'b0010) begin bad++; $display("FAIL lb_be got=%b exp=0010", cap_be); end
    total++; if (done_data !== 32'h00000012) begin bad++; $display("FAIL lb_data got=%h exp=00000012", done_data); end
    total++; if (stall_cnt != 3) begin bad++; $display("FAIL lb_stall got=%0d exp=3", stall_cnt); end
    // A store must leave the last load result in place.
    run_access(1'b0, 1'b1, 32'h10, 32'h11223344, 3'b010, 1, 32'hFFFFFFFF);
    total++; if (done_data !== 32'h00000012) begin bad++; $display("FAIL store_keeps_data got=%h exp=00000012", done_data); end
  endtask

  task automatic test_misaligned;
    run_access(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 1, 32'hCAFEF00D);
    total++; if (timed_out) begin bad++; $display("FAIL mis_timeout got=1 exp=0"); end
`ifdef MISALIGN_TRAP_EN
    total++; if (req_cnt != 0) begin bad++; $display("FAIL mis_no_req got=%0d exp=0", req_cnt); end
    total++; if (stall_cnt != 1) begin bad++; $display("FAIL mis_stall got=%0d exp=1", stall_cnt); end
    total++; if (done_exc !== 1'b1) begin bad++; $display("FAIL mis_exc got=%b exp=1", done_exc); end
    total++; if (post_exc !== 1'b0) begin bad++; $display("FAIL mis_exc_pulse got=%b exp=0", post_exc); end
`else
    total++; if (cap_addr !== 32'h100) begin bad++; $display("FAIL mis_addr got=%h exp=00000100", cap_addr); end
    total++; if (cap_be !== 4'b1111) begin bad++; $display("FAIL mis_be got=%b exp=1111", cap_be); end
    total++; if (done_data !== 32'hCAFEF00D) begin bad++; $display("FAIL mis_data got=%h exp=cafef00d", done_data); end
    total++; if (exc_cnt != 0) begin bad++; $display("FAIL mis_exc got=%0d exp=0", exc_cnt); end
`endif
  endtask

  task automatic test_reset_mid_bus;
    @(posedge clk); #1;
    mem_rd_en = 1'b1; alu_result = 32'h400; mem_funct3 = 3'b010;
    @(posedge clk); #1;
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rb_in_bus got=%b exp=1", dmem_req); end
    rst = 1'b1; mem_rd_en = 1'b0;
    #1;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rb_req_drop got=%b exp=0", dmem_req); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rb_stall got=%b exp=0", stall); end
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    total++; if (data !== 32'h0) begin bad++; $display("FAIL rb_data got=%h exp=0", data); end
    total++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rb_idle got=%b%b exp=00", dmem_req, stall); end
    run_access(1'b0, 1'b1, 32'h104, 32'h0000BEEF, 3'b001, 1, 32'h0);
    total++; if (stall_cnt != 2 || cap_be !== 4'b0011) begin bad++; $display("FAIL rb_next_access got=%0d/%b exp=2/0011", stall_cnt, cap_be); end
    total++; if (cap_wdata !== 32'hBEEFBEEF) begin bad++; $display("FAIL sh_wdata got=%h exp=beefbeef", cap_wdata); end
  endtask

  initial begin
    test_reset;
    test_sw_fast;
    test_sb_slow;
    test_loads;
    test_misaligned;
    test_reset_mid_bus;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
